// File: rtl/smbm_cmd_sched.sv
// ---------------------------------------------------------------------------
// smbm_cmd_sched
//   Round-robin command scheduler in front of a single sorted multi-metric
//   buffer manager (SMBM). Accepts ADD / DELETE / READ requests from NUM_REQ
//   requesters, issues one command at a time on the SMBM opcode interface,
//   waits for sm_done and returns a response. ADD on a full buffer and DELETE
//   on an empty buffer are answered with an error and never reach the SMBM.
//
// Optional feature macro: SMBM_SCHED_TIMEOUT_EN
//   When defined, a watchdog ends WAIT after TIMEOUT cycles without sm_done
//   and answers with err 11. When undefined, WAIT ends only on sm_done.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   req_valid/ready   per-requester handshake (ready = one-hot grant, IDLE only)
//   req_op            2 bits/requester: 00 ADD, 01 DELETE, 10 READ, 11 reserved
//   req_id/metric/rdvec/metricx/rdmode  per-requester command arguments
//   sm_opcode         SMBM opcode, 3'b111 = no-op
//   sm_id/metric/in/metricx/opcode_in   SMBM arguments, held from grant to done
//   sm_done           SMBM completion pulse (only honoured in WAIT)
//   rsp_valid/ready   response handshake
//   rsp_req, rsp_err  answered requester index, status (00 ok, 01 full,
//                     10 empty, 11 timeout / reserved op)
//   occupancy         number of entries the SMBM currently holds
// ---------------------------------------------------------------------------
module smbm_cmd_sched #(
  parameter int NUM_REQ            = 4,
  parameter int NUM_REQ_LOG        = 2,
  parameter int BIT_VEC_SIZE       = 64,
  parameter int BIT_VEC_SIZE_LOG   = 6,
  parameter int NUM_OF_METRICS     = 8,
  parameter int NUM_OF_METRICS_LOG = 3,
  parameter int TIMEOUT            = 64
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_REQ-1:0]                    req_valid,
  output logic [NUM_REQ-1:0]                    req_ready,
  input  logic [2*NUM_REQ-1:0]                  req_op,
  input  logic [NUM_REQ*BIT_VEC_SIZE_LOG-1:0]   req_id,
  input  logic [NUM_REQ*NUM_OF_METRICS*8-1:0]   req_metric,
  input  logic [NUM_REQ*BIT_VEC_SIZE-1:0]       req_rdvec,
  input  logic [NUM_REQ*NUM_OF_METRICS_LOG-1:0] req_metricx,
  input  logic [3*NUM_REQ-1:0]                  req_rdmode,
  output logic [2:0]                            sm_opcode,
  output logic [BIT_VEC_SIZE_LOG-1:0]           sm_id,
  output logic [NUM_OF_METRICS*8-1:0]           sm_metric,
  output logic [BIT_VEC_SIZE-1:0]               sm_in,
  output logic [NUM_OF_METRICS_LOG-1:0]         sm_metricx,
  output logic [2:0]                            sm_opcode_in,
  input  logic                                  sm_done,
  output logic                                  rsp_valid,
  input  logic                                  rsp_ready,
  output logic [NUM_REQ_LOG-1:0]                rsp_req,
  output logic [1:0]                            rsp_err,
  output logic [BIT_VEC_SIZE_LOG:0]             occupancy
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ISSUE = 2'd1, ST_WAIT = 2'd2, ST_RESP = 2'd3} state_t;

  localparam int                       OCC_W    = BIT_VEC_SIZE_LOG + 1;
  localparam logic [1:0]               OP_ADD   = 2'b00;
  localparam logic [1:0]               OP_DEL   = 2'b01;
  localparam logic [1:0]               OP_READ  = 2'b10;
  localparam logic [2:0]               SM_NOP   = 3'b111;
  localparam logic [1:0]               ERR_OK   = 2'b00;
  localparam logic [1:0]               ERR_FULL = 2'b01;
  localparam logic [1:0]               ERR_EMPT = 2'b10;
  localparam logic [1:0]               ERR_TMO  = 2'b11;
  localparam logic [OCC_W-1:0]         OCC_FULL = OCC_W'(BIT_VEC_SIZE);
  localparam logic [OCC_W-1:0]         OCC_ZERO = {OCC_W{1'b0}};
  localparam logic [OCC_W-1:0]         OCC_ONE  = OCC_W'(1);

  state_t                         state_r, state_nxt_s;
  logic [NUM_REQ_LOG-1:0]         ptr_r;
  logic [NUM_REQ_LOG-1:0]         grant_idx_s;
  logic                           grant_any_s;
  logic [NUM_REQ-1:0]             grant_s;
  logic [1:0]                     grant_op_s;
  logic [1:0]                     grant_err_s;
  logic [1:0]                     op_r;
  logic [OCC_W-1:0]               occ_r;
  logic                           tmo_hit_s;
  logic [2:0]                     sm_opcode_r;
  logic [BIT_VEC_SIZE_LOG-1:0]    sm_id_r;
  logic [NUM_OF_METRICS*8-1:0]    sm_metric_r;
  logic [BIT_VEC_SIZE-1:0]        sm_in_r;
  logic [NUM_OF_METRICS_LOG-1:0]  sm_metricx_r;
  logic [2:0]                     sm_opcode_in_r;
  logic                           rsp_valid_r;
  logic [NUM_REQ_LOG-1:0]         rsp_req_r;
  logic [1:0]                     rsp_err_r;

  // Round-robin pick: first valid requester searching upward from ptr_r, with wrap.
  always_comb begin
    logic [NUM_REQ_LOG-1:0] cand_v;
    grant_idx_s = {NUM_REQ_LOG{1'b0}};
    grant_any_s = 1'b0;
    cand_v      = {NUM_REQ_LOG{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      cand_v = ptr_r + NUM_REQ_LOG'(i);
      if (!grant_any_s && req_valid[cand_v]) begin
        grant_any_s = 1'b1;
        grant_idx_s = cand_v;
      end else begin
        grant_any_s = grant_any_s;
      end
    end
    if (grant_any_s) begin
      grant_s = NUM_REQ'(1) << grant_idx_s;
    end else begin
      grant_s = {NUM_REQ{1'b0}};
    end
  end

  assign req_ready  = (state_r == ST_IDLE) ? grant_s : {NUM_REQ{1'b0}};
  assign grant_op_s = req_op[{grant_idx_s, 1'b0} +: 2];

  // Legality of the granted op against the current occupancy.
  always_comb begin
    grant_err_s = ERR_OK;
    case (grant_op_s)
      OP_ADD:  grant_err_s = (occ_r == OCC_FULL) ? ERR_FULL : ERR_OK;
      OP_DEL:  grant_err_s = (occ_r == OCC_ZERO) ? ERR_EMPT : ERR_OK;
      OP_READ: grant_err_s = ERR_OK;
      default: grant_err_s = ERR_TMO;
    endcase
  end

`ifdef SMBM_SCHED_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_cnt_r;

  // Watchdog: cleared in ISSUE so it reads 0 on the first WAIT cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_r <= {TMO_W{1'b0}};
    end else if (state_r == ST_ISSUE) begin
      tmo_cnt_r <= {TMO_W{1'b0}};
    end else if (state_r == ST_WAIT) begin
      tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
    end else begin
      tmo_cnt_r <= tmo_cnt_r;
    end
  end

  // Fires on the TIMEOUT-th WAIT cycle, so RESP starts TIMEOUT cycles after WAIT entry.
  assign tmo_hit_s = (state_r == ST_WAIT) && (tmo_cnt_r == TMO_W'(TIMEOUT - 1));
`else
  // Without the watchdog this is constant 0: WAIT ends only on sm_done.
  assign tmo_hit_s = (TIMEOUT < 0);
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (grant_any_s) begin
          if (grant_err_s == ERR_OK) begin
            state_nxt_s = ST_ISSUE;
          end else begin
            state_nxt_s = ST_RESP;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ISSUE: state_nxt_s = ST_WAIT;
      ST_WAIT: begin
        if (sm_done || tmo_hit_s) begin
          state_nxt_s = ST_RESP;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RESP;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Datapath: argument capture at grant, one-cycle opcode, occupancy, response.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r          <= {NUM_REQ_LOG{1'b0}};
      op_r           <= 2'b00;
      occ_r          <= OCC_ZERO;
      sm_opcode_r    <= SM_NOP;
      sm_id_r        <= {BIT_VEC_SIZE_LOG{1'b0}};
      sm_metric_r    <= {(NUM_OF_METRICS*8){1'b0}};
      sm_in_r        <= {BIT_VEC_SIZE{1'b0}};
      sm_metricx_r   <= {NUM_OF_METRICS_LOG{1'b0}};
      sm_opcode_in_r <= 3'b000;
      rsp_valid_r    <= 1'b0;
      rsp_req_r      <= {NUM_REQ_LOG{1'b0}};
      rsp_err_r      <= ERR_OK;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (grant_any_s) begin
            ptr_r          <= grant_idx_s + NUM_REQ_LOG'(1);
            op_r           <= grant_op_s;
            rsp_req_r      <= grant_idx_s;
            sm_id_r        <= req_id[grant_idx_s*BIT_VEC_SIZE_LOG +: BIT_VEC_SIZE_LOG];
            sm_metric_r    <= req_metric[grant_idx_s*NUM_OF_METRICS*8 +: NUM_OF_METRICS*8];
            sm_in_r        <= req_rdvec[grant_idx_s*BIT_VEC_SIZE +: BIT_VEC_SIZE];
            sm_metricx_r   <= req_metricx[grant_idx_s*NUM_OF_METRICS_LOG +: NUM_OF_METRICS_LOG];
            sm_opcode_in_r <= req_rdmode[grant_idx_s*3 +: 3];
            if (grant_err_s == ERR_OK) begin
              sm_opcode_r <= {1'b0, grant_op_s};
            end else begin
              // Rejected ops skip the SMBM and answer straight away.
              rsp_valid_r <= 1'b1;
              rsp_err_r   <= grant_err_s;
            end
          end else begin
            ptr_r <= ptr_r;
          end
        end
        ST_ISSUE: sm_opcode_r <= SM_NOP;
        ST_WAIT: begin
          if (sm_done) begin
            rsp_valid_r <= 1'b1;
            rsp_err_r   <= ERR_OK;
            if (op_r == OP_ADD) begin
              occ_r <= occ_r + OCC_ONE;
            end else if (op_r == OP_DEL) begin
              occ_r <= occ_r - OCC_ONE;
            end else begin
              occ_r <= occ_r;
            end
          end else if (tmo_hit_s) begin
            rsp_valid_r <= 1'b1;
            rsp_err_r   <= ERR_TMO;
          end else begin
            rsp_valid_r <= 1'b0;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
          end else begin
            rsp_valid_r <= 1'b1;
          end
        end
        default: sm_opcode_r <= SM_NOP;
      endcase
    end
  end

  assign sm_opcode    = sm_opcode_r;
  assign sm_id        = sm_id_r;
  assign sm_metric    = sm_metric_r;
  assign sm_in        = sm_in_r;
  assign sm_metricx   = sm_metricx_r;
  assign sm_opcode_in = sm_opcode_in_r;
  assign rsp_valid    = rsp_valid_r;
  assign rsp_req      = rsp_req_r;
  assign rsp_err      = rsp_err_r;
  assign occupancy    = occ_r;

endmodule
